// File: rtl/half_adder_checker.sv
// Receiving end of the half-adder test path: accepts {Bit1,Bit2,Sum,Carry}
// vectors over valid/ready, recomputes the expected outputs and keeps run results.
module half_adder_checker #(
   parameter int NUM_VECTORS = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             Bit1,
   input  logic             Bit2,
   input  logic             Sum,
   input  logic             Carry,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic [CNT_W-1:0] first_fail_idx,
   output logic [3:0]       first_fail_vec,
   output logic             error,
   output logic [3:0]       coverage,
   output logic             all_covered,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   typedef struct packed {logic b1; logic b2; logic s; logic c;} vec_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_VECTORS - 1);

   state_t           state;
   vec_t             in_vec, stg_vec;
   logic             stg_vld, accept, stg_bad;
   logic [CNT_W-1:0] stg_idx, acc_cnt;

   assign in_vec      = {Bit1, Bit2, Sum, Carry};
   assign accept      = in_valid && (state == RUN);
   assign stg_bad     = (stg_vec.s != (stg_vec.b1 ^ stg_vec.b2)) ||
                        (stg_vec.c != (stg_vec.b1 & stg_vec.b2));
   assign all_covered = &coverage;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         in_ready       <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         stg_vld        <= 1'b0;
         stg_vec        <= '0;
         stg_idx        <= '0;
         acc_cnt        <= '0;
         pass_count     <= '0;
         fail_count     <= '0;
         first_fail_idx <= '0;
         first_fail_vec <= '0;
         error          <= 1'b0;
         coverage       <= '0;
      end else begin
         // compare stage: one cycle behind the accept, never stalls
         if (stg_vld) begin
            if (stg_bad) begin
               if (fail_count != CNT_MAX) fail_count <= fail_count + 1'b1;
               if (!error) begin
                  error          <= 1'b1;
                  first_fail_idx <= stg_idx;
                  first_fail_vec <= stg_vec;
               end
            end else if (pass_count != CNT_MAX) begin
               pass_count <= pass_count + 1'b1;
            end
         end

         stg_vld <= accept;
         if (accept) begin
            stg_vec                <= in_vec;
            stg_idx                <= acc_cnt;
            acc_cnt                <= acc_cnt + 1'b1;
            coverage[{Bit1, Bit2}] <= 1'b1;
         end

         case (state)
            IDLE, DONE: if (start) begin
               state          <= RUN;
               in_ready       <= 1'b1;
               busy           <= 1'b1;
               done           <= 1'b0;
               acc_cnt        <= '0;
               pass_count     <= '0;
               fail_count     <= '0;
               first_fail_idx <= '0;
               first_fail_vec <= '0;
               error          <= 1'b0;
               coverage       <= '0;
            end
            RUN: if (accept && acc_cnt == LAST) begin
               state    <= DRAIN;
               in_ready <= 1'b0;
            end
            DRAIN: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
